traffic_sequencer: RTL
======================

Name: traffic_sequencer

Overview:
- Main/side intersection controller that sequences the time-parameter store.
- Drives the 2-bit interval select, waits out the store's registered lookup, loads a seconds countdown and steps through the light phases.
- Handles the side-street sensor and a latched pedestrian walk request, and restarts cleanly after reprogramming.
- Sits between the synchronisers / 1 Hz divider and the lamp drivers.

Parameters:
- INT_BASE, 2'b00, interval code for the base time
- INT_EXT, 2'b01, interval code for the extended time
- INT_YEL, 2'b10, interval code for the yellow time
- LOAD_WAIT, 2, cycles between an interval change and capturing the value (one store register plus one margin)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- one_hz_en  in  1  single-cycle strobe, once per second
- sensor_sync  in  1  side-street traffic present (synchronised)
- walk_req_sync  in  1  pedestrian request pulse (synchronised)
- prog_sync  in  1  reprogramming in progress (synchronised)
- value  in  4  seconds for the currently selected interval, from the store
- interval  out  2  interval select to the store
- main_lights  out  3  {red,yellow,green} for the main street, one-hot
- side_lights  out  3  {red,yellow,green} for the side street, one-hot
- walk_lamp  out  1  pedestrian walk indicator
- countdown  out  4  remaining seconds in the current phase

Behaviour:
- Phases: MG_BASE, MG_EXT, MG_YEL, WALK, SG_BASE, SG_EXT, SG_YEL.
- Lights per phase:
  - MG_*: main green, side red.
  - MG_YEL: main yellow, side red.
  - WALK: both red, walk_lamp=1.
  - SG_*: main red, side green.
  - SG_YEL: main red, side yellow.
- Interval per phase:
  - *_BASE: INT_BASE.
  - *_EXT and WALK: INT_EXT.
  - *_YEL: INT_YEL.
  - interval is registered and updates on the same edge as the phase.
- Phase entry:
  - A load sub-phase of LOAD_WAIT cycles runs first. The timer is frozen and one_hz_en is ignored during it.
  - On the final load cycle the timer captures value. A captured value of 0 is loaded as 1; 15 (store default code) is loaded as is.
- Counting: timer decrements on one_hz_en. The phase expires on a one_hz_en cycle with timer==1. The next phase and its load sub-phase start on the following edge. A phase therefore lasts value seconds plus LOAD_WAIT cycles.
- Transitions on expiry:
  - MG_BASE -> MG_YEL if sensor_sync=1 at the expiry cycle, else MG_EXT.
  - MG_EXT -> MG_YEL.
  - MG_YEL -> WALK if walk_pending, else SG_BASE.
  - WALK -> SG_BASE.
  - SG_BASE -> SG_EXT if sensor_sync=1, else SG_YEL.
  - SG_EXT -> SG_YEL.
  - SG_YEL -> MG_BASE.
- walk_pending:
  - Set by walk_req_sync in any cycle; cleared on the edge entering WALK.
  - A request arriving on the entry cycle is kept for the next cycle round.
  - At most one WALK per cycle round.
- prog_sync=1 (priority over counting and expiry):
  - State forced to MG_BASE, held in its load sub-phase, timer=0.
  - Outputs all-red, walk_lamp=0, interval=INT_BASE.
  - walk_pending is retained.
  - On the first cycle with prog_sync=0 the full LOAD_WAIT sub-phase restarts, so freshly programmed values are used.
- countdown = timer. It reads 0 during load sub-phases.
- Reset (async assert, sync deassert is the upstream's job). All of the following take effect immediately:
  - state=MG_BASE in load sub-phase, load counter=0, timer=0, walk_pending=0, interval=INT_BASE.
  - main_lights=3'b001, side_lights=3'b100, walk_lamp=0, countdown=0.
  - Reset mid-phase abandons the phase with no yellow.
- Lamp outputs are registered and glitch-free. Exactly one lamp per street is on, except during prog_sync.

Test Plan:
- Reset, value tied 6/3/2 by interval, sensor=0, no walk, one_hz_en every 4 clocks -> phases MG_BASE(6s) MG_EXT(3s) MG_YEL(2s) SG_BASE(6s) SG_YEL(2s) MG_BASE; interval sequence 00,01,10,00,10,00.
- sensor=1 held -> MG_BASE goes directly to MG_YEL; SG_BASE goes to SG_EXT for 3s.
- walk_req_sync pulse during MG_BASE -> WALK for 3s after MG_YEL with both red and walk_lamp=1. A second pulse on the WALK-entry cycle -> WALK again next round only.
- Change value from 6 to 9 one cycle after an interval change -> timer captures 9 (LOAD_WAIT respected). value=0 -> 1s phase. value=15 -> 15s phase.
- prog_sync asserted mid SG_BASE for 5 cycles -> all-red, countdown=0. After release, LOAD_WAIT cycles then MG_BASE loads the new value.
- reset_n pulsed low between clock edges during MG_YEL -> outputs return to reset values without waiting for a clock edge. walk_pending is cleared.

Source files
------------

// File: rtl/traffic_sequencer_if.sv
// Signal bundle between the traffic sequencer, its input synchronisers,
// the time-parameter store and the lamp drivers.
interface traffic_sequencer_if;
  logic       one_hz_en;
  logic       sensor_sync;
  logic       walk_req_sync;
  logic       prog_sync;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;
  logic [3:0] countdown;

  modport master (
    output one_hz_en, sensor_sync, walk_req_sync, prog_sync, value,
    input  interval, main_lights, side_lights, walk_lamp, countdown
  );

  modport slave (
    input  one_hz_en, sensor_sync, walk_req_sync, prog_sync, value,
    output interval, main_lights, side_lights, walk_lamp, countdown
  );
endinterface

// File: rtl/traffic_sequencer.sv
// Main/side intersection controller: selects a store interval, waits out the
// store lookup, counts the captured seconds down and steps the light phases.
module traffic_sequencer #(
  parameter logic [1:0]  INT_BASE  = 2'b00,
  parameter logic [1:0]  INT_EXT   = 2'b01,
  parameter logic [1:0]  INT_YEL   = 2'b10,
  parameter int unsigned LOAD_WAIT = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  traffic_sequencer_if.slave  bus
);

  localparam int unsigned LCNT_W    = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
  localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_WAIT - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    MG_YEL  = 3'd2,
    WALK    = 3'd3,
    SG_BASE = 3'd4,
    SG_EXT  = 3'd5,
    SG_YEL  = 3'd6
  } phase_e;

  phase_e            state_q, state_d, expiry_next;
  logic              loading_q, loading_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [3:0]        timer_q, timer_d;
  logic              walk_pend_q, walk_pend_d;
  logic [1:0]        interval_q, interval_d;
  logic [2:0]        main_q, main_d;
  logic [2:0]        side_q, side_d;
  logic              walk_lamp_q, walk_lamp_d;

  // Phase that follows the current one when its timer runs out.
  always_comb begin
    expiry_next = MG_BASE;
    case (state_q)
      MG_BASE: expiry_next = bus.sensor_sync ? MG_YEL : MG_EXT;
      MG_EXT:  expiry_next = MG_YEL;
      MG_YEL:  expiry_next = walk_pend_q ? WALK : SG_BASE;
      WALK:    expiry_next = SG_BASE;
      SG_BASE: expiry_next = bus.sensor_sync ? SG_EXT : SG_YEL;
      SG_EXT:  expiry_next = SG_YEL;
      SG_YEL:  expiry_next = MG_BASE;
      default: expiry_next = MG_BASE;
    endcase
  end

  // Next state, load sub-phase, timer, walk latch and registered lamp values.
  always_comb begin
    state_d     = state_q;
    loading_d   = loading_q;
    lcnt_d      = lcnt_q;
    timer_d     = timer_q;
    walk_pend_d = walk_pend_q | bus.walk_req_sync;
    main_d      = LAMP_RED;
    side_d      = LAMP_RED;
    walk_lamp_d = 1'b0;
    interval_d  = INT_BASE;

    if (bus.prog_sync) begin
      state_d   = MG_BASE;
      loading_d = 1'b1;
      lcnt_d    = '0;
      timer_d   = 4'd0;
    end else if (loading_q) begin
      if (lcnt_q == LOAD_LAST) begin
        loading_d = 1'b0;
        lcnt_d    = '0;
        timer_d   = (bus.value == 4'd0) ? 4'd1 : bus.value;
      end else begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end
    end else if (bus.one_hz_en) begin
      if (timer_q == 4'd1) begin
        state_d   = expiry_next;
        loading_d = 1'b1;
        lcnt_d    = '0;
        timer_d   = 4'd0;
        // A request on the WALK entry cycle carries over to the next round.
        if (expiry_next == WALK) walk_pend_d = bus.walk_req_sync;
      end else begin
        timer_d = timer_q - 4'd1;
      end
    end

    if (!bus.prog_sync) begin
      case (state_d)
        MG_BASE, MG_EXT: begin main_d = LAMP_GRN; interval_d = (state_d == MG_EXT) ? INT_EXT : INT_BASE; end
        MG_YEL:          begin main_d = LAMP_YEL; interval_d = INT_YEL; end
        WALK:            begin walk_lamp_d = 1'b1; interval_d = INT_EXT; end
        SG_BASE, SG_EXT: begin side_d = LAMP_GRN; interval_d = (state_d == SG_EXT) ? INT_EXT : INT_BASE; end
        SG_YEL:          begin side_d = LAMP_YEL; interval_d = INT_YEL; end
        default:         begin main_d = LAMP_GRN; end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MG_BASE;
      loading_q   <= 1'b1;
      lcnt_q      <= '0;
      timer_q     <= 4'd0;
      walk_pend_q <= 1'b0;
      interval_q  <= INT_BASE;
      main_q      <= LAMP_GRN;
      side_q      <= LAMP_RED;
      walk_lamp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      loading_q   <= loading_d;
      lcnt_q      <= lcnt_d;
      timer_q     <= timer_d;
      walk_pend_q <= walk_pend_d;
      interval_q  <= interval_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_lamp_q <= walk_lamp_d;
    end
  end

  assign bus.interval    = interval_q;
  assign bus.main_lights = main_q;
  assign bus.side_lights = side_q;
  assign bus.walk_lamp   = walk_lamp_q;
  assign bus.countdown   = timer_q;

endmodule
